gshare_bpred: RTL

Parametrised two-level (gshare) branch predictor with a direct-mapped branch target buffer, the successor to the one-level predictor in the 5-stage MIPS pipeline. Looked up combinationally by the fetch stage every cycle and trained by the execute stage on every resolved branch. Holds a speculative global history register (GHR) that is repaired on misprediction.

---
 rtl/bpred_pkg.sv | 28 ++
 rtl/bpred_btb.sv | 66 ++++++
 rtl/gshare_bpred.sv | 93 +++++++++
 3 files changed

// File: rtl/bpred_pkg.sv
// Shared branch-predictor helpers: counter reset value,
// saturating counter steps and the gshare index hash.
package bpred_pkg;

  localparam int MAX_W = 32;

  typedef logic [MAX_W-1:0] word_t;

  function automatic word_t ctr_reset(input int w);
    return word_t'((1 << (w - 1)) - 1);
  endfunction

  function automatic word_t sat_inc(input word_t c, input int w);
    word_t mx;
    mx = word_t'((64'd1 << w) - 64'd1);
    return (c >= mx) ? mx : c + word_t'(1);
  endfunction

  function automatic word_t sat_dec(input word_t c);
    return (c == '0) ? '0 : c - word_t'(1);
  endfunction

  function automatic word_t idx_hash(input word_t idx,
                                    input word_t ghr);
    return idx ^ ghr;
  endfunction

endpackage

// File: rtl/bpred_btb.sv
// Direct-mapped branch target buffer, combinational lookup.
// BTB_TAG_EN adds per-entry tags; otherwise aliasing PCs share entries.
module bpred_btb #(
  parameter int ENTRIES = 1024,
  parameter int ADDR_W  = 32,
  parameter int TAG_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lk_pc_i,
  output logic              lk_hit_o,
  output logic [ADDR_W-1:0] lk_target_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_pc_i,
  input  logic [ADDR_W-1:0] wr_target_i
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] r_valid;
  logic [ADDR_W-1:0]  r_target [ENTRIES];
  logic [IDX_W-1:0]   w_lk_idx;
  logic [IDX_W-1:0]   w_wr_idx;
  logic               w_unused_pc;

  assign w_lk_idx    = lk_pc_i[IDX_W+1:2];
  assign w_wr_idx    = wr_pc_i[IDX_W+1:2];
  assign lk_target_o = r_target[w_lk_idx];
  assign w_unused_pc = ^{lk_pc_i, wr_pc_i};

`ifdef BTB_TAG_EN
  logic [TAG_W-1:0] r_tag [ENTRIES];
  logic [TAG_W-1:0] w_lk_tag;
  logic [TAG_W-1:0] w_wr_tag;

  assign w_lk_tag = lk_pc_i[IDX_W+1+TAG_W:IDX_W+2];
  assign w_wr_tag = wr_pc_i[IDX_W+1+TAG_W:IDX_W+2];
  assign lk_hit_o = r_valid[w_lk_idx] &&
                    (r_tag[w_lk_idx] == w_lk_tag);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++)
        r_tag[i] <= '0;
    end else if (wr_en_i) begin
      r_tag[w_wr_idx] <= w_wr_tag;
    end
  end
`else
  localparam int unused_tag_w = TAG_W;

  assign lk_hit_o = r_valid[w_lk_idx];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++)
        r_target[i] <= '0;
    end else if (wr_en_i) begin
      r_valid[w_wr_idx]  <= 1'b1;
      r_target[w_wr_idx] <= wr_target_i;
    end
  end

endmodule

// File: rtl/gshare_bpred.sv
// Gshare direction predictor with speculative, repairable GHR.
// Optional BTB tags via BTB_TAG_EN (see bpred_btb).
module gshare_bpred
  import bpred_pkg::*;
#(
  parameter int ENTRIES = 1024,
  parameter int GHR_W   = 8,
  parameter int CTR_W   = 2,
  parameter int ADDR_W  = 32,
  parameter int TAG_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_fetch_i,
  input  logic              fetch_adv_i,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  output logic [GHR_W-1:0]  pred_ghr_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic [GHR_W-1:0]  upd_ghr_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_mispred_i
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [CTR_W-1:0]  r_pht [ENTRIES];
  logic [GHR_W-1:0]  r_ghr;

  logic [IDX_W-1:0]  w_f_pht_idx;
  logic [IDX_W-1:0]  w_u_pht_idx;
  logic              w_hit;
  logic [ADDR_W-1:0] w_btb_tgt;
  logic [CTR_W-1:0]  w_u_ctr;
  logic [CTR_W-1:0]  w_u_ctr_nxt;
  logic [GHR_W-1:0]  w_ghr_spec;
  logic [GHR_W-1:0]  w_ghr_fix;

  assign w_f_pht_idx = IDX_W'(idx_hash(word_t'(pc_fetch_i[IDX_W+1:2]),
                                       word_t'(r_ghr)));
  assign w_u_pht_idx = IDX_W'(idx_hash(word_t'(upd_pc_i[IDX_W+1:2]),
                                       word_t'(upd_ghr_i)));

  bpred_btb #(
    .ENTRIES (ENTRIES),
    .ADDR_W  (ADDR_W),
    .TAG_W   (TAG_W)
  ) u_btb (
    .clk         (clk),
    .reset       (reset),
    .lk_pc_i     (pc_fetch_i),
    .lk_hit_o    (w_hit),
    .lk_target_o (w_btb_tgt),
    .wr_en_i     (upd_valid_i & upd_taken_i),
    .wr_pc_i     (upd_pc_i),
    .wr_target_i (upd_target_i)
  );

  assign pred_taken_o  = w_hit & r_pht[w_f_pht_idx][CTR_W-1];
  assign pred_target_o = pred_taken_o ? w_btb_tgt
                                      : pc_fetch_i + ADDR_W'(4);
  assign pred_ghr_o    = r_ghr;

  // Low GHR_W bits of the concatenation also covers GHR_W == 1.
  assign w_ghr_spec = GHR_W'({r_ghr, pred_taken_o});
  assign w_ghr_fix  = GHR_W'({upd_ghr_i, upd_taken_i});

  assign w_u_ctr     = r_pht[w_u_pht_idx];
  assign w_u_ctr_nxt = upd_taken_i
                     ? CTR_W'(sat_inc(word_t'(w_u_ctr), CTR_W))
                     : CTR_W'(sat_dec(word_t'(w_u_ctr)));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++)
        r_pht[i] <= CTR_W'(ctr_reset(CTR_W));
    end else if (upd_valid_i) begin
      r_pht[w_u_pht_idx] <= w_u_ctr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_ghr <= '0;
    else if (upd_valid_i && upd_mispred_i)
      r_ghr <= w_ghr_fix;
    else if (fetch_adv_i && w_hit)
      r_ghr <= w_ghr_spec;
  end

endmodule
